// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Brief    : Write-back select, 2**ADDR_W-entry register file (entry 0 reads
//            as zero), two combinational read ports, a forwarding tap and a
//            retired-write counter.
//            Optional macro WB_BYPASS_EN: read-during-write bypass on the read
//            ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] PCnew_EX_WB,
    input  logic [DATA_W-1:0] ResultALU_EX_WB,
    input  logic [DATA_W-1:0] imm_EX_WB,
    input  logic [ADDR_W-1:0] RegRd_EX_WB,
    input  logic              RegWrite_EX_WB,
    input  logic              jumpIns_EX_WB,
    input  logic              valueToReg_EX_WB,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [c_depth];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Link PC has priority over the immediate, which has priority over the ALU.
    always_comb begin
        wb_data = ResultALU_EX_WB;
        if (jumpIns_EX_WB) begin
            wb_data = PCnew_EX_WB;
        end else if (valueToReg_EX_WB) begin
            wb_data = imm_EX_WB;
        end
    end

    assign wb_valid   = RegWrite_EX_WB && (RegRd_EX_WB != '0);
    assign wb_rd      = RegRd_EX_WB;
    assign retire_cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (wb_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < c_depth; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (wb_valid) begin
                regs_q[RegRd_EX_WB] <= wb_data;
            end
            cnt_q <= cnt_d;
        end
    end

    // Address 0 is forced to zero here, so entry 0 never needs protecting.
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
        if (wb_valid && (rs1_addr == RegRd_EX_WB)) begin
            rs1_data = wb_data;
        end
        if (wb_valid && (rs2_addr == RegRd_EX_WB)) begin
            rs2_data = wb_data;
        end
`else
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Self-checking bench for wb_regfile: directed steps followed by
//            randomized traffic checked against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    logic       clk;
    logic       Reset;
    logic [7:0] pc, alu, imm;
    logic [4:0] rd, rs1, rs2;
    logic       regwrite, jump, v2r;

    logic [7:0]  rs1_data, rs2_data, wb_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [15:0] retire_cnt;

    logic [7:0]  s_rs1_data, s_rs2_data, s_wb_data;
    logic        s_wb_valid;
    logic [4:0]  s_wb_rd;
    logic [3:0]  s_retire_cnt;

    int nvec = 0;
    int nerr = 0;

    // Reference state
    logic [7:0] m_reg [32];
    int         m_cnt;
    int         m_cnt4;

    wb_regfile #(.DATA_W(8), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .Reset(Reset),
        .PCnew_EX_WB(pc), .ResultALU_EX_WB(alu), .imm_EX_WB(imm),
        .RegRd_EX_WB(rd), .RegWrite_EX_WB(regwrite),
        .jumpIns_EX_WB(jump), .valueToReg_EX_WB(v2r),
        .rs1_addr(rs1), .rs2_addr(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .retire_cnt(retire_cnt)
    );

    wb_regfile #(.DATA_W(8), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .Reset(Reset),
        .PCnew_EX_WB(pc), .ResultALU_EX_WB(alu), .imm_EX_WB(imm),
        .RegRd_EX_WB(rd), .RegWrite_EX_WB(regwrite),
        .jumpIns_EX_WB(jump), .valueToReg_EX_WB(v2r),
        .rs1_addr(rs1), .rs2_addr(rs2),
        .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .wb_data(s_wb_data),
        .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .retire_cnt(s_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_wb();
        if (jump) return pc;
        if (v2r)  return imm;
        return alu;
    endfunction

    function automatic logic exp_valid();
        return regwrite && (rd != 5'd0);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 8'h00;
`ifdef WB_BYPASS_EN
        if (exp_valid() && a == rd) return exp_wb();
`endif
        return m_reg[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    // Check every output against the model mid-cycle, then commit one edge.
    task automatic step();
        @(negedge clk);
        chk("rs1_data", rs1_data, exp_rd(rs1));
        chk("rs2_data", rs2_data, exp_rd(rs2));
        chk("wb_data", wb_data, exp_wb());
        chk("wb_valid", wb_valid, exp_valid());
        chk("wb_rd", wb_rd, rd);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("retire_cnt4", s_retire_cnt, m_cnt4);
        chk("rs1_data_4", s_rs1_data, exp_rd(rs1));
        @(posedge clk);
        if (Reset) begin
            model_clear();
        end else if (exp_valid()) begin
            m_reg[rd] = exp_wb();
            m_cnt     = (m_cnt + 1) % 65536;
            m_cnt4    = (m_cnt4 + 1) % 16;
        end
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] d, input logic j, input logic v,
                         input logic [7:0] p, input logic [7:0] a, input logic [7:0] im);
        regwrite = w; rd = d; jump = j; v2r = v; pc = p; alu = a; imm = im;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rs1 = 5'd0; rs2 = 5'd0;
        @(posedge clk);
        #1;
        model_clear();

        // All entries read zero after reset
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rs1 = 5'(i); rs2 = 5'(i + 16);
            #1;
            chk("reset_rs1", rs1_data, 8'h00);
            chk("reset_rs2", rs2_data, 8'h00);
            step();
        end
        chk("reset_cnt", retire_cnt, 16'd0);

        // Basic ALU write to r5
        drive(1'b1, 5'd5, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h00);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rs1 = 5'd5;
        #1;
        chk("r5_alu", rs1_data, 8'h3C);
        chk("cnt_after_r5", retire_cnt, 16'd1);
        step();

        // Select priority: jump beats immediate beats ALU
        drive(1'b1, 5'd7, 1'b1, 1'b1, 8'h21, 8'h55, 8'h99);
        step();
        drive(1'b1, 5'd8, 1'b0, 1'b1, 8'h21, 8'h55, 8'h99);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rs1 = 5'd7; rs2 = 5'd8;
        #1;
        chk("prio_jump", rs1_data, 8'h21);
        chk("prio_imm", rs2_data, 8'h99);
        step();

        // Writes to r0 are discarded
        drive(1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
        rs1 = 5'd0;
        #1;
        chk("r0_valid", wb_valid, 1'b0);
        chk("r0_read", rs1_data, 8'h00);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #1;
        chk("r0_cnt", retire_cnt, 16'd3);
        chk("r0_after", rs1_data, 8'h00);
        step();

        // Same-cycle read of the register being written
        drive(1'b1, 5'd3, 1'b0, 1'b0, 8'h00, 8'h11, 8'h00);
        step();
        drive(1'b1, 5'd3, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h00);
        rs2 = 5'd3;
        #1;
`ifdef WB_BYPASS_EN
        chk("rw_same_cycle", rs2_data, 8'hA5);
`else
        chk("rw_same_cycle", rs2_data, 8'h11);
`endif
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #1;
        chk("rw_next_cycle", rs2_data, 8'hA5);
        step();

        // Reset wins over a concurrent write
        Reset = 1'b1;
        drive(1'b1, 5'd4, 1'b0, 1'b0, 8'h00, 8'h44, 8'h00);
        step();
        Reset = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        rs1 = 5'd4; rs2 = 5'd5;
        #1;
        chk("rst_vs_write", rs1_data, 8'h00);
        chk("rst_clears_r5", rs2_data, 8'h00);
        chk("rst_cnt", retire_cnt, 16'd0);
        chk("rst_cnt4", s_retire_cnt, 4'd0);
        step();

        // 17 effective writes wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 1'b0, 1'b0, 8'h00, 8'(i * 7 + 1), 8'h00);
            step();
        end
        drive(1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #1;
        chk("wrap_cnt4", s_retire_cnt, 4'd1);
        chk("wrap_cnt16", retire_cnt, 16'd17);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            Reset    = ($urandom_range(0, 59) == 0);
            regwrite = $urandom_range(0, 3) != 0;
            rd       = 5'($urandom);
            jump     = $urandom_range(0, 3) == 0;
            v2r      = $urandom_range(0, 2) == 0;
            pc       = 8'($urandom);
            alu      = 8'($urandom);
            imm      = 8'($urandom);
            rs1      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            rs2      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
